// File: rtl/uncache_axi_bridge_if.sv
// AXI4 single-beat read/write channels between the uncache bridge and memory.
// master: bridge side (drives valids/addr/data); slave: memory side.
interface uncache_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arsize, rready,
    output awvalid, awaddr, awsize,
    output wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata_i, rresp,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arsize, rready,
    input  awvalid, awaddr, awsize,
    input  wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata_i, rresp,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/uncache_axi_bridge.sv
// Turns one held uncached request into one single-beat AXI4 read or write.
// Ports: clk, resetn (sync, active-low), req_* in, reload/rdata/resp_err out, axi master.
module uncache_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_en,
  input  logic [3:0]        req_wsel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              reload,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_err,
  uncache_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_next;
  logic   w_next;

  // Low response bits carry no meaning for completion status.
  logic unused_resp;
  assign unused_resp = ^{axi.rresp[0], axi.bresp[0]};

  function automatic logic [2:0] size_of(input logic [3:0] s);
    logic [2:0] z;
    case (s)
      4'b1111:                            z = 3'd2;
      4'b0011, 4'b1100:                   z = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: z = 3'd0;
      default:                            z = 3'd2;
    endcase
    return z;
  endfunction

  // AW and W retire independently; include a handshake in this cycle.
  always_comb begin
    aw_next = aw_done | (axi.awvalid & axi.awready);
    w_next  = w_done  | (axi.wvalid  & axi.wready);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      reload      <= 1'b0;
      rdata       <= '0;
      resp_err    <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arsize  <= 3'b010;
      axi.rready  <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awsize  <= 3'd0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= 4'd0;
      axi.bready  <= 1'b0;
    end else begin
      reload <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_en) begin
            if (req_wsel == 4'd0) begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_ADDR;
            end else begin
              axi.awaddr  <= req_addr;
              axi.awsize  <= size_of(req_wsel);
              axi.wdata   <= req_wdata;
              axi.wstrb   <= req_wsel;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi.arvalid && axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid && axi.rready) begin
            rdata      <= axi.rdata_i;
            resp_err   <= axi.rresp[1];
            axi.rready <= 1'b0;
            reload     <= 1'b1;
            state      <= DONE;
          end
        end
        WR_ADDR: begin
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready)   axi.wvalid  <= 1'b0;
          aw_done <= aw_next;
          w_done  <= w_next;
          if (aw_next && w_next) begin
            axi.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid && axi.bready) begin
            resp_err   <= axi.bresp[1];
            axi.bready <= 1'b0;
            reload     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
